// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU/result codes, immediate
// formats and the ID/EX pipeline payload.
package riscv_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREGS  = 32;
  localparam int unsigned REG_AW = 5;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef enum logic [1:0] {IMM_I, IMM_S, IMM_B, IMM_J} imm_src_e;

  typedef struct packed {
    logic              reg_write;
    logic              mem_write;
    logic [1:0]        result_src;
    logic              alu_src;
    logic [2:0]        alu_ctrl;
    logic              branch;
    logic              jump;
    logic [XLEN-1:0]   rd1;
    logic [XLEN-1:0]   rd2;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   pc_plus4;
  } idex_t;

  // sub_en is only set for R-type, where funct7[5] selects subtract
  function automatic logic [2:0] alu_decode(input logic [2:0] funct3, input logic sub_en);
    logic [2:0] op;
    case (funct3)
      3'b000:  op = sub_en ? ALU_SUB : ALU_ADD;
      3'b010:  op = ALU_SLT;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_cycle_register_file.sv
// 32x32 register file: two async reads, one sync write, x0 hard-wired to 0.
// Optional write-through bypass under DECODE_BYPASS_EN.
module register_file
  import riscv_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] raddr1_i,
  input  logic [REG_AW-1:0] raddr2_i,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [XLEN-1:0]   wdata_i,
  output logic [XLEN-1:0]   rdata1_o_c,
  output logic [XLEN-1:0]   rdata2_o_c
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic            wr_en;

  assign wr_en = we_i && (waddr_i != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata1_o_c = '0;
    rdata2_o_c = '0;
    if (raddr1_i != '0) rdata1_o_c = regs_q[raddr1_i];
    if (raddr2_i != '0) rdata2_o_c = regs_q[raddr2_i];
`ifdef DECODE_BYPASS_EN
    // write-through: the value being written this cycle is visible now
    if (wr_en && (waddr_i == raddr1_i)) rdata1_o_c = wdata_i;
    if (wr_en && (waddr_i == raddr2_i)) rdata2_o_c = wdata_i;
`endif
  end

endmodule

// File: rtl/decode_cycle.sv
// RV32I decode stage: control decode, register read, immediate extend,
// registered into ID/EX. Optional WB->ID bypass: DECODE_BYPASS_EN.
module decode_cycle
  import riscv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   InstrD,
  input  logic [XLEN-1:0]   PCD,
  input  logic [XLEN-1:0]   PCPlus4D,
  input  logic              RegWriteW,
  input  logic [REG_AW-1:0] RDW,
  input  logic [XLEN-1:0]   ResultW,
  input  logic              FlushE,
  output logic              RegWriteE,
  output logic              MemWriteE,
  output logic [1:0]        ResultSrcE,
  output logic              ALUSrcE,
  output logic [2:0]        ALUControlE,
  output logic              BranchE,
  output logic              JumpE,
  output logic [XLEN-1:0]   RD1E,
  output logic [XLEN-1:0]   RD2E,
  output logic [XLEN-1:0]   ImmExtE,
  output logic [REG_AW-1:0] RS1E,
  output logic [REG_AW-1:0] RS2E,
  output logic [REG_AW-1:0] RDE,
  output logic [XLEN-1:0]   PCE,
  output logic [XLEN-1:0]   PCPlus4E
);

  logic [XLEN-1:0] rd1, rd2, imm_ext;
  imm_src_e        imm_src;
  idex_t           idex_d, idex_q;

  register_file u_rf (
    .clk        (clk),
    .rst_n      (rst),
    .raddr1_i   (InstrD[19:15]),
    .raddr2_i   (InstrD[24:20]),
    .we_i       (RegWriteW),
    .waddr_i    (RDW),
    .wdata_i    (ResultW),
    .rdata1_o_c (rd1),
    .rdata2_o_c (rd2)
  );

  // Control decode; unknown opcodes leave every control bit at 0
  always_comb begin
    idex_d  = '0;
    imm_src = IMM_I;
    case (InstrD[6:0])
      OP_LW: begin
        idex_d.reg_write  = 1'b1;
        idex_d.alu_src    = 1'b1;
        idex_d.result_src = RES_MEM;
      end
      OP_SW: begin
        idex_d.mem_write = 1'b1;
        idex_d.alu_src   = 1'b1;
        imm_src          = IMM_S;
      end
      OP_R: begin
        idex_d.reg_write = 1'b1;
        idex_d.alu_ctrl  = alu_decode(InstrD[14:12], InstrD[30]);
      end
      OP_I: begin
        idex_d.reg_write = 1'b1;
        idex_d.alu_src   = 1'b1;
        idex_d.alu_ctrl  = alu_decode(InstrD[14:12], 1'b0);
      end
      OP_BEQ: begin
        idex_d.branch   = 1'b1;
        idex_d.alu_ctrl = ALU_SUB;
        imm_src         = IMM_B;
      end
      OP_JAL: begin
        idex_d.jump       = 1'b1;
        idex_d.reg_write  = 1'b1;
        idex_d.result_src = RES_PC4;
        imm_src           = IMM_J;
      end
      default: ;
    endcase
    idex_d.rd1      = rd1;
    idex_d.rd2      = rd2;
    idex_d.imm      = imm_ext;
    idex_d.rs1      = InstrD[19:15];
    idex_d.rs2      = InstrD[24:20];
    idex_d.rd       = InstrD[11:7];
    idex_d.pc       = PCD;
    idex_d.pc_plus4 = PCPlus4D;
    if (FlushE) idex_d = '0;
  end

  always_comb begin
    imm_ext = '0;
    case (imm_src)
      IMM_I: imm_ext = {{20{InstrD[31]}}, InstrD[31:20]};
      IMM_S: imm_ext = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      IMM_B: imm_ext = {{19{InstrD[31]}}, InstrD[31], InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
      IMM_J: imm_ext = {{11{InstrD[31]}}, InstrD[31], InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
      default: imm_ext = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) idex_q <= '0;
    else      idex_q <= idex_d;
  end

  assign RegWriteE   = idex_q.reg_write;
  assign MemWriteE   = idex_q.mem_write;
  assign ResultSrcE  = idex_q.result_src;
  assign ALUSrcE     = idex_q.alu_src;
  assign ALUControlE = idex_q.alu_ctrl;
  assign BranchE     = idex_q.branch;
  assign JumpE       = idex_q.jump;
  assign RD1E        = idex_q.rd1;
  assign RD2E        = idex_q.rd2;
  assign ImmExtE     = idex_q.imm;
  assign RS1E        = idex_q.rs1;
  assign RS2E        = idex_q.rs2;
  assign RDE         = idex_q.rd;
  assign PCE         = idex_q.pc;
  assign PCPlus4E    = idex_q.pc_plus4;

endmodule

// File: tb/tb_decode_cycle.sv
// Self-checking bench for decode_cycle: directed scenarios plus randomized
// instructions against a behavioural decode/register-file model.
module tb_decode_cycle;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic [1:0]  result_src;
    logic        alu_src;
    logic [2:0]  alu_ctrl;
    logic        branch;
    logic        jump;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] pc4;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] InstrD = '0, PCD = '0, PCPlus4D = '0, ResultW = '0;
  logic        RegWriteW = 1'b0, FlushE = 1'b0;
  logic [4:0]  RDW = '0;
  logic        RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0]  RS1E, RS2E, RDE;

  int checks = 0;
  int errors = 0;
  logic [31:0] mregs [32];

  decode_cycle dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW), .FlushE(FlushE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
    .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE), .BranchE(BranchE), .JumpE(JumpE),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .RS1E(RS1E), .RS2E(RS2E),
    .RDE(RDE), .PCE(PCE), .PCPlus4E(PCPlus4E)
  );

  always #5 clk = ~clk;

  function automatic obs_t observe();
    return {RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, ALUControlE, BranchE, JumpE,
            RD1E, RD2E, ImmExtE, RS1E, RS2E, RDE, PCE, PCPlus4E};
  endfunction

  function automatic logic [31:0] rd_model(input logic [4:0] idx, input logic wen,
                                           input logic [4:0] rdw, input logic [31:0] res);
    if (idx == 5'd0) return 32'd0;
`ifdef DECODE_BYPASS_EN
    if (wen && rdw == idx) return res;
`endif
    return mregs[idx];
  endfunction

  // Immediates built as signed sums of weighted fields
  function automatic void decode_model(input logic [31:0] ins, input logic [31:0] pc,
                                       input logic [31:0] r1, input logic [31:0] r2,
                                       output obs_t e, output obs_t m);
    int imm;
    int f3;
    logic is_r;
    e = '0;
    m = '1;
    f3 = int'(ins[14:12]);
    is_r = (ins[6:0] == 7'b0110011);
    imm = 0;
    case (ins[6:0])
      7'b0000011: begin e.reg_write = 1; e.alu_src = 1; e.result_src = 2'b01;
                        imm = int'(ins[30:20]) - int'(ins[31]) * 2048; m.alu_ctrl = '0; end
      7'b0100011: begin e.mem_write = 1; e.alu_src = 1;
                        imm = int'(ins[11:7]) + int'(ins[30:25]) * 32 - int'(ins[31]) * 2048;
                        m.alu_ctrl = '0; end
      7'b0110011: begin e.reg_write = 1; m.imm = '0; end
      7'b0010011: begin e.reg_write = 1; e.alu_src = 1;
                        imm = int'(ins[30:20]) - int'(ins[31]) * 2048; end
      7'b1100011: begin e.branch = 1; e.alu_ctrl = 3'b001;
                        imm = int'(ins[11:8]) * 2 + int'(ins[30:25]) * 32 + int'(ins[7]) * 2048
                              - int'(ins[31]) * 4096; end
      7'b1101111: begin e.jump = 1; e.reg_write = 1; e.result_src = 2'b10;
                        imm = int'(ins[30:21]) * 2 + int'(ins[20]) * 2048 + int'(ins[19:12]) * 4096
                              - int'(ins[31]) * (1 << 20); m.alu_ctrl = '0; end
      default: m.imm = '0;
    endcase
    if (ins[6:0] == 7'b0110011 || ins[6:0] == 7'b0010011) begin
      if (f3 == 0)      e.alu_ctrl = (is_r && ins[30]) ? 3'b001 : 3'b000;
      else if (f3 == 2) e.alu_ctrl = 3'b101;
      else if (f3 == 6) e.alu_ctrl = 3'b011;
      else if (f3 == 7) e.alu_ctrl = 3'b010;
      else              e.alu_ctrl = 3'b000;
    end
    e.imm = 32'(imm);
    e.rd1 = r1;
    e.rd2 = r2;
    e.rs1 = ins[19:15];
    e.rs2 = ins[24:20];
    e.rd  = ins[11:7];
    e.pc  = pc;
    e.pc4 = pc + 32'd4;
  endfunction

  // Drive one cycle of inputs, predict ID/EX, advance to the next negedge
  task automatic step(input logic [31:0] ins, input logic [31:0] pc, input logic wen,
                      input logic [4:0] rdw, input logic [31:0] res, input logic flush,
                      output obs_t e, output obs_t m);
    InstrD = ins; PCD = pc; PCPlus4D = pc + 32'd4;
    RegWriteW = wen; RDW = rdw; ResultW = res; FlushE = flush;
    decode_model(ins, pc, rd_model(ins[19:15], wen, rdw, res),
                 rd_model(ins[24:20], wen, rdw, res), e, m);
    if (flush) begin e = '0; m = '1; end
    @(posedge clk);
    if (wen && rdw != 5'd0) mregs[rdw] = res;
    @(negedge clk);
    RegWriteW = 1'b0;
    FlushE = 1'b0;
  endtask

  task automatic test_reset();
    obs_t e, m, o;
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    InstrD = 32'h00500093; PCD = 32'h100; PCPlus4D = 32'h104;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    o = observe();
    if (o !== '0) begin errors++; $display("FAIL reset_hold: got %h exp 0", o); end
    rst = 1'b1;
    step(32'h00500093, 32'h100, 1'b0, 5'd0, '0, 1'b0, e, m);
    checks++;
    if (RDE !== 5'd1 || ImmExtE !== 32'd5 || ALUSrcE !== 1'b1 || RegWriteE !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: got rd=%0d imm=%h alusrc=%b rw=%b exp rd=1 imm=5 alusrc=1 rw=1",
               RDE, ImmExtE, ALUSrcE, RegWriteE);
    end
    checks++;
    o = observe();
    if ((o & m) !== (e & m)) begin errors++; $display("FAIL reset_release_model: got %h exp %h", o, e); end
  endtask

  task automatic test_wb_read();
    obs_t e, m, o;
    step(32'h00000013, 32'h200, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, e, m);
    step(32'h00028133, 32'h204, 1'b0, 5'd0, '0, 1'b0, e, m);
    checks++;
    if (RD1E !== 32'hDEADBEEF || RD2E !== 32'd0 || ALUControlE !== 3'b000) begin
      errors++;
      $display("FAIL wb_read: got rd1=%h rd2=%h alu=%b exp rd1=deadbeef rd2=0 alu=000",
               RD1E, RD2E, ALUControlE);
    end
    checks++;
    o = observe();
    if ((o & m) !== (e & m)) begin errors++; $display("FAIL wb_read_model: got %h exp %h", o, e); end
  endtask

  task automatic test_x0();
    obs_t e, m;
    step(32'h00000013, 32'h300, 1'b1, 5'd0, 32'h1234, 1'b0, e, m);
    step(32'h000001B3, 32'h304, 1'b0, 5'd0, '0, 1'b0, e, m);  // add x3,x0,x0
    checks++;
    if (RD1E !== 32'd0) begin errors++; $display("FAIL x0_protect: got %h exp 0", RD1E); end
  endtask

  task automatic test_imm();
    obs_t e, m, o;
    step(32'hFE000EE3, 32'h400, 1'b0, 5'd0, '0, 1'b0, e, m);
    checks++;
    if (ImmExtE !== 32'hFFFFFFFC || BranchE !== 1'b1 || ALUControlE !== 3'b001) begin
      errors++;
      $display("FAIL imm_beq: got imm=%h br=%b alu=%b exp imm=fffffffc br=1 alu=001",
               ImmExtE, BranchE, ALUControlE);
    end
    checks++;
    o = observe();
    if ((o & m) !== (e & m)) begin errors++; $display("FAIL imm_beq_model: got %h exp %h", o, e); end
    step(32'h001000EF, 32'h404, 1'b0, 5'd0, '0, 1'b0, e, m);  // jal x1,+2048
    checks++;
    if (ImmExtE !== 32'h00000800 || JumpE !== 1'b1 || ResultSrcE !== 2'b10) begin
      errors++;
      $display("FAIL imm_jal: got imm=%h j=%b rs=%b exp imm=00000800 j=1 rs=10",
               ImmExtE, JumpE, ResultSrcE);
    end
  endtask

  task automatic test_flush();
    obs_t e, m, o;
    step(32'h40628233, 32'h500, 1'b1, 5'd7, 32'hCAFE0007, 1'b1, e, m);  // sub x4,x5,x6
    checks++;
    o = observe();
    if (o !== '0) begin errors++; $display("FAIL flush_bubble: got %h exp 0", o); end
    step(32'h00038433, 32'h504, 1'b0, 5'd0, '0, 1'b0, e, m);  // add x8,x7,x0
    checks++;
    if (RD1E !== 32'hCAFE0007) begin errors++; $display("FAIL flush_wb: got %h exp cafe0007", RD1E); end
  endtask

  task automatic test_bypass();
    obs_t e, m;
    logic [31:0] exp_v;
    step(32'h00000013, 32'h600, 1'b1, 5'd3, 32'h11, 1'b0, e, m);
    step(32'h00018233, 32'h604, 1'b1, 5'd3, 32'h55, 1'b0, e, m);  // add x4,x3,x0
`ifdef DECODE_BYPASS_EN
    exp_v = 32'h55;
`else
    exp_v = 32'h11;
`endif
    checks++;
    if (RD1E !== exp_v) begin errors++; $display("FAIL same_cycle_rw: got %h exp %h", RD1E, exp_v); end
  endtask

  task automatic test_random();
    obs_t e, m, o;
    logic [6:0]  ops [8];
    logic [31:0] ins, r;
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
            7'b1100011, 7'b1101111, 7'b0110111, 7'b1111111};
    for (int i = 0; i < 300; i++) begin
      r = $urandom();
      ins = {r[31:7], ops[$urandom_range(0, 7)]};
      ins[17:15] = 3'($urandom_range(0, 7)); ins[19:18] = 2'b00;
      ins[22:20] = 3'($urandom_range(0, 7)); ins[24:23] = 2'b00;
      step(ins, $urandom(), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
           $urandom(), ($urandom_range(0, 9) == 0), e, m);
      checks++;
      o = observe();
      if ((o & m) !== (e & m)) begin
        errors++;
        $display("FAIL random[%0d] ins=%h: got %h exp %h", i, ins, o, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_wb_read();
    test_x0();
    test_imm();
    test_flush();
    test_bypass();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_cycle.md
Name: decode_cycle

Overview:
- Decode stage of the 5-stage RV32I pipeline; consumes the IF/ID outputs of the fetch stage (instruction, PC, PC+4).
- Decodes control, reads and writes the 32x32 register file, and sign-extends immediates.
- Registers everything into the ID/EX pipeline register for the execute stage.
- Also accepts the writeback port from WB and a flush from the branch/hazard logic.

Parameters:
- XLEN, 32, data/address width
- NREGS, 32, architectural register count (index width 5)

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-low reset
- InstrD  in  32  instruction from IF/ID
- PCD  in  32  PC of InstrD
- PCPlus4D  in  32  PC+4 of InstrD
- RegWriteW  in  1  writeback enable
- RDW  in  5  writeback destination
- ResultW  in  32  writeback data
- FlushE  in  1  insert bubble into ID/EX (taken branch/jump)
- RegWriteE  out  1  register write enable
- MemWriteE  out  1  store enable
- ResultSrcE  out  2  00 ALU, 01 memory, 10 PC+4
- ALUSrcE  out  1  0 RD2, 1 immediate
- ALUControlE  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- BranchE  out  1  beq
- JumpE  out  1  jal
- RD1E  out  32  rs1 data
- RD2E  out  32  rs2 data
- ImmExtE  out  32  sign-extended immediate
- RS1E  out  5  rs1 index
- RS2E  out  5  rs2 index
- RDE  out  5  rd index
- PCE  out  32  PC
- PCPlus4E  out  32  PC+4

Behaviour:
- Reset (rst=0, asynchronous): every ID/EX output is 0 and all 32 registers are cleared. Outputs stay 0 while rst is held low. Release is synchronous to the next clk edge.
- Latency: 1 cycle. Values decoded from InstrD at edge N appear on the *E outputs after edge N.
- Supported opcodes:
  - 0000011 lw: RegWrite=1, ALUSrc=1, ResultSrc=01, imm type I
  - 0100011 sw: MemWrite=1, ALUSrc=1, imm type S
  - 0110011 R-type: RegWrite=1, ALU op from funct3/funct7[5]
  - 0010011 I-ALU: RegWrite=1, ALUSrc=1, imm type I
  - 1100011 beq: Branch=1, ALUControl=001, imm type B
  - 1101111 jal: Jump=1, RegWrite=1, ResultSrc=10, imm type J
- ALU decode:
  - funct3 000: sub only when R-type and funct7[5]=1; otherwise add.
  - funct3 010: slt.
  - funct3 110: or.
  - funct3 111: and.
  - Any other funct3: add.
- Unknown opcode: all control outputs 0 (architectural no-op). Data fields are still registered.
- Immediate extend (sign bit is always InstrD[31]):
  - I: [31:20]
  - S: {[31:25],[11:7]}
  - B: {[31],[7],[30:25],[11:8],0}
  - J: {[31],[19:12],[20],[30:21],0}
- Register file:
  - Write on rising clk when RegWriteW=1 and RDW!=0.
  - Writes to x0 are discarded; reads of x0 always return 0.
  - Two asynchronous read ports, indexed by InstrD[19:15] and InstrD[24:20].
- FlushE=1 at an edge: the ID/EX register loads all zeros (bubble), overriding the decoded values. The register-file write in that same cycle still happens.
- Simultaneous write and read of the same register in one cycle: see DECODE_BYPASS_EN.
- Writeback still proceeds while FlushE is asserted; flush affects ID/EX only.

Optional Feature:
- Macro: DECODE_BYPASS_EN
- Defined: write-through bypass. If RegWriteW=1, RDW!=0 and RDW equals rs1 (or rs2), the read port returns ResultW in the same cycle, so the new value is registered into RD1E/RD2E at that edge.
- Undefined: the read port returns the stored (old) value. The hazard unit must stall or forward across the WB→ID gap.

Decomposition:
- Shared package riscv_pkg holds:
  - opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL)
  - ALUControl codes
  - ResultSrc codes
  - ImmSrc enum (IMM_I, IMM_S, IMM_B, IMM_J)
- One natural sub-module: register_file (32x32, two async reads, one sync write, async active-low clear, bypass under the macro).
- Control decode and immediate extend stay in decode_cycle.

Test Plan:
1. Reset: hold rst=0 with InstrD=0x00500093 → all *E outputs 0. Release; one edge later RDE=1, ImmExtE=5, ALUSrcE=1, RegWriteE=1.
2. Writeback then read: RegWriteW=1, RDW=5, ResultW=0xDEADBEEF for one edge, then InstrD=0x00028133 (add x2,x5,x0) → RD1E=0xDEADBEEF, RD2E=0, ALUControlE=000.
3. x0 protection: RegWriteW=1, RDW=0, ResultW=0x1234, then an instruction reading x0 → RD1E=0.
4. Immediates: beq encoding offset -4 (0xFE000EE3) → ImmExtE=0xFFFFFFFC, BranchE=1, ALUControlE=001. jal x1,+2048 → ImmExtE=0x00000800, JumpE=1, ResultSrcE=10.
5. Flush: valid sub instruction with FlushE=1 → all *E outputs 0 next cycle; a concurrent writeback to x7 is still visible on a later read.
6. Same-cycle write/read of x3 (ResultW=0x55): with DECODE_BYPASS_EN, RD1E=0x55; without it, RD1E equals the old x3 value.
